// File: rtl/apb_uart_sink_pkg.sv
// apb_uart_sink shared definitions: register offsets,
// LSR bit positions and the access FSM state type.
package apb_uart_sink_pkg;

  localparam logic [11:0] OFF_THR = 12'h000;
  localparam logic [11:0] OFF_LSR = 12'h014;
  localparam logic [11:0] OFF_SCR = 12'h01C;
  localparam logic [11:0] OFF_WIN = 12'h020;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/apb_uart_sink_if.sv
// APB3 bus bundle between the SoC uart requester and
// the apb_uart_sink completer.
interface apb_uart_sink_if #(
  parameter int AddrWidth = 32
);
  logic                 psel_i;
  logic                 penable_i;
  logic                 pwrite_i;
  logic [AddrWidth-1:0] paddr_i;
  logic [31:0]          pwdata_i;
  logic [31:0]          prdata_o;
  logic                 pready_o;
  logic                 pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i,
    output paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i,
    input  paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_uart_sink_fifo.sv
// Byte TX queue for apb_uart_sink (fifo_v3-style ports),
// power-of-two depth so pointers wrap naturally.
module apb_uart_sink_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign full_o  = (r_cnt == (PW+1)'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/apb_uart_sink.sv
// APB3 16550-style UART sink: THR bytes queue and drain paced on a stream.
// Define APB_UART_SINK_PRINT_EN to echo drained bytes to the sim console.
module apb_uart_sink
  import apb_uart_sink_pkg::*;
#(
  parameter int AddrWidth  = 32,
  parameter int FifoDepth  = 16,
  parameter int WaitStates = 1,
  parameter int DrainGap   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  apb_uart_sink_if.slave  apb,
  output logic            char_valid_o,
  output logic [7:0]      char_o,
  input  logic            char_ready_i
);
  localparam int CW = (WaitStates > 1) ? $clog2(WaitStates) : 1;
  localparam int GW = (DrainGap > 0) ? $clog2(DrainGap + 1) : 1;

  state_e        r_state;
  state_e        w_state_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_scr;

  logic [11:0]   w_off;
  logic          w_err;
  logic          w_thr;
  logic          w_stall;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [31:0]   w_rdata;

  assign w_off   = apb.paddr_i[11:0];
  assign w_err   = (w_off >= OFF_WIN) | (w_off[1:0] != 2'b00);
  assign w_thr   = apb.pwrite_i & ~w_err & (w_off == OFF_THR);
  assign w_stall = w_thr & w_full;
  assign w_resp  = (r_state == RESP) & apb.psel_i;
  assign w_push  = w_resp & w_thr;

  // The idle cycle that sees penable counts as the first access cycle
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (apb.psel_i & apb.penable_i) begin
          w_cnt_d   = CW'(WaitStates - 1);
          w_state_d = (WaitStates == 1 && !w_stall) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!apb.psel_i) begin
          w_state_d = IDLE;
        end else if (r_cnt > CW'(1)) begin
          w_cnt_d = r_cnt - CW'(1);
        end else begin
          w_cnt_d = '0;
          if (!w_stall) w_state_d = RESP;
        end
      end
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scr <= '0;
    end else if (w_resp & apb.pwrite_i & ~w_err & (w_off == OFF_SCR)) begin
      r_scr <= apb.pwdata_i[7:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_resp & ~apb.pwrite_i & ~w_err) begin
      unique case (1'b1)
        (w_off == OFF_LSR): begin
          w_rdata[LSR_DR]   = 1'b0;
          w_rdata[LSR_THRE] = w_empty;
          w_rdata[LSR_TEMT] = w_empty & ~char_valid_o;
        end
        (w_off == OFF_SCR): w_rdata[7:0] = r_scr;
        default:            w_rdata = '0;
      endcase
    end
  end

  assign apb.prdata_o  = w_rdata;
  assign apb.pready_o  = (r_state == RESP);
  assign apb.pslverr_o = (r_state == RESP) & w_err;

  apb_uart_sink_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (apb.pwdata_i[7:0]),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign char_valid_o = ~w_empty & (r_gap == '0);
  assign char_o       = char_valid_o ? w_head : 8'h00;
  assign w_pop        = char_valid_o & char_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gap <= '0;
    end else if (w_pop) begin
      r_gap <= GW'(DrainGap);
    end else if (r_gap != '0) begin
      r_gap <= r_gap - GW'(1);
    end
  end

`ifdef APB_UART_SINK_PRINT_EN
  always @(posedge clk_i) begin
    if (rst_ni && w_pop) begin
      $write("%c", char_o);
      if (char_o == 8'h04) begin
        $display("EOT");
        $finish;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_apb_uart_sink.sv
// Scoreboard bench for apb_uart_sink: APB responses and
// drained bytes are queued at issue and checked by monitors.
module tb_apb_uart_sink;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_uart_sink_if #(.AddrWidth(32)) apb();

  logic       char_valid;
  logic [7:0] ch;
  logic       char_ready = 1'b0;

  apb_uart_sink #(
    .AddrWidth  (32),
    .FifoDepth  (16),
    .WaitStates (1),
    .DrainGap   (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .apb          (apb),
    .char_valid_o (char_valid),
    .char_o       (ch),
    .char_ready_i (char_ready)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  rsp_t       q_rsp[$];
  logic [7:0] q_char[$];
  int         q_pop_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && apb.pready_o) begin
      if (q_rsp.size() == 0) begin
        fail_now("apb_unexpected_response");
      end else begin
        e = q_rsp.pop_front();
        chk("apb_prdata", apb.prdata_o, e.rdata);
        chk("apb_pslverr", {31'b0, apb.pslverr_o}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && char_valid && char_ready) begin
      q_pop_t.push_back(cyc);
      if (q_char.size() == 0) begin
        $display("FAIL char_unexpected: got %0h", ch);
        checks++;
        failures++;
      end else begin
        e = q_char.pop_front();
        chk("char_data", {24'b0, ch}, {24'b0, e});
      end
    end
  end

  initial begin
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
    apb.pwrite_i  = 1'b0;
    apb.paddr_i   = '0;
    apb.pwdata_i  = '0;
  end

  task automatic apb_xfer(input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd,
                          input bit exp_err, output int lat);
    @(posedge clk);
    #1;
    apb.psel_i    = 1'b1;
    apb.penable_i = 1'b0;
    apb.pwrite_i  = wr;
    apb.paddr_i   = addr;
    apb.pwdata_i  = data;
    q_rsp.push_back(rsp_t'{exp_rd, exp_err});
    if (wr && addr == 32'h0) q_char.push_back(data[7:0]);
    @(posedge clk);
    #1 apb.penable_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!apb.pready_o && lat < 300);
    if (!apb.pready_o) fail_now("apb_timeout");
    @(posedge clk);
    #1;
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
    @(negedge clk);
    chk("pready_single_cycle", {31'b0, apb.pready_o}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit err);
    int l;
    apb_xfer(1'b1, a, d, 32'h0, err, l);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input bit err);
    int l;
    apb_xfer(1'b0, a, 32'h0, exp, err, l);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q_char.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_complete", q_char.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int lat;
    int lat17;
    #2;
    chk("rst_prdata", apb.prdata_o, 0);
    chk("rst_pready", {31'b0, apb.pready_o}, 0);
    chk("rst_pslverr", {31'b0, apb.pslverr_o}, 0);
    chk("rst_char_valid", {31'b0, char_valid}, 0);
    chk("rst_char", {24'b0, ch}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    rd(32'h14, 32'h60, 1'b0);

    char_ready = 1'b1;
    apb_xfer(1'b1, 32'h0, 32'h41, 32'h0, 1'b0, lat);
    chk("thr_latency", lat, 2);
    wait_drain();

    char_ready = 1'b0;
    wr(32'h0, 32'h42, 1'b0);
    rd(32'h14, 32'h00, 1'b0);
    char_ready = 1'b1;
    wait_drain();
    rd(32'h14, 32'h60, 1'b0);

    char_ready = 1'b0;
    wr(32'h0, 32'h11, 1'b0);
    wr(32'h0, 32'h22, 1'b0);
    wr(32'h0, 32'h33, 1'b0);
    q_pop_t.delete();
    @(posedge clk);
    #1 char_ready = 1'b1;
    wait_drain();
    chk("gap_pop_count", q_pop_t.size(), 3);
    if (q_pop_t.size() >= 3) begin
      chk("gap_spacing_1", q_pop_t[1] - q_pop_t[0], 5);
      chk("gap_spacing_2", q_pop_t[2] - q_pop_t[1], 5);
    end

    wr(32'h1C, 32'hA5A5_A5C3, 1'b0);
    rd(32'h1C, 32'h0000_00C3, 1'b0);
    rd(32'h04, 32'h0, 1'b0);
    rd(32'h20, 32'h0, 1'b1);
    rd(32'h02, 32'h0, 1'b1);
    wr(32'h1E, 32'h11, 1'b1);
    wr(32'h3C, 32'h22, 1'b1);
    wr(32'h01, 32'h77, 1'b1);
    rd(32'hABCD_E01C, 32'h0000_00C3, 1'b0);

    char_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apb_xfer(1'b1, 32'h0, i, 32'h0, 1'b0, lat);
      chk("fill_latency", lat, 2);
    end
    fork
      apb_xfer(1'b1, 32'h0, 32'd16, 32'h0, 1'b0, lat17);
      begin
        repeat (20) @(posedge clk);
        #1 char_ready = 1'b1;
        @(posedge clk);
        #1 char_ready = 1'b0;
      end
    join
    chk("stall_held", {31'b0, (lat17 > 20)}, 32'h1);
    char_ready = 1'b1;
    wait_drain();

    char_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(32'h0, 32'h80 + i, 1'b0);
    @(posedge clk);
    #1;
    apb.psel_i    = 1'b1;
    apb.pwrite_i  = 1'b1;
    apb.paddr_i   = 32'h0;
    apb.pwdata_i  = 32'h99;
    @(posedge clk);
    #1 apb.penable_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_pready_low", {31'b0, apb.pready_o}, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_prdata", apb.prdata_o, 0);
    chk("mid_rst_pready", {31'b0, apb.pready_o}, 0);
    chk("mid_rst_pslverr", {31'b0, apb.pslverr_o}, 0);
    chk("mid_rst_char_valid", {31'b0, char_valid}, 0);
    chk("mid_rst_char", {24'b0, ch}, 0);
    q_char.delete();
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
    char_ready    = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(32'h14, 32'h60, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("post_rst_no_char", {31'b0, char_valid}, 0);

    chk("rsp_queue_empty", q_rsp.size(), 0);
    chk("char_queue_empty", q_char.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_uart_sink.md
Name: apb_uart_sink

Overview:
APB3 completer that terminates the SoC's uart_* APB requester port in simulation and FPGA-less bring-up.
- Accepts 16550-style register accesses and queues THR bytes in a TX FIFO.
- Drains bytes at a paced rate on a valid/ready character stream.
- Reports line status so the software putchar loop sees realistic THRE/TEMT behaviour and backpressure.

Parameters:
AddrWidth, 32, paddr_i width.
FifoDepth, 16, TX FIFO entries; power of two, ≥2.
WaitStates, 1, extra access-phase cycles before pready_o; ≥1.
DrainGap, 4, idle cycles forced after each drained byte; 0 = back-to-back.

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
pwrite_i  in  1  1 = write
paddr_i  in  AddrWidth  byte address
pwdata_i  in  32  write data
prdata_o  out  32  read data, valid with pready_o
pready_o  out  1  transfer complete
pslverr_o  out  1  error, valid with pready_o
char_valid_o  out  1  drained byte available
char_o  out  8  drained byte
char_ready_i  in  1  consumer accepts byte

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous, active-low, on rst_ni. Reset clears FSM to IDLE, FIFO, counters, SCR.
- Reset values: prdata_o=0, pready_o=0, pslverr_o=0, char_valid_o=0, char_o=0.
- Address decode: offset = paddr_i[11:0]; bits above 11 are ignored because base decode is upstream.
  - Error if offset ≥ 0x20 or paddr_i[1:0]≠0. Error transfers have no side effect, prdata_o=0, pslverr_o=1.
- Register map:
  - 0x00 THR (W): push pwdata_i[7:0].
  - 0x00 RBR (R): reads 0.
  - 0x14 LSR (R): bit0 DR=0; bit5 THRE=FIFO empty; bit6 TEMT=FIFO empty and char_valid_o=0; other bits 0.
  - 0x1C SCR (R/W): 8-bit scratch, upper bits read 0.
  - All other in-range word offsets: writes ignored, reads 0, no error.
- FSM states:
  - IDLE: move to WAIT on psel_i&penable_i; the counter loads WaitStates-1.
  - WAIT: counter decrements each cycle. At 0 it moves to RESP unless the access is a THR write with FIFO full; it stalls there, pready_o=0, until the FIFO count < FifoDepth.
  - RESP: pready_o=1 for exactly one cycle (registered). Side effects (push, SCR update) happen in this cycle, with prdata_o/pslverr_o driven. Next state is IDLE.
- Latency: the access phase lasts exactly WaitStates+1 cycles when unstalled.
- Protocol misuse: psel_i dropped mid-access returns to IDLE with no side effect.
- FIFO push and pop:
  - The fullness check uses the registered count, with no same-cycle bypass.
  - Pop and push in the same cycle are legal.
  - FIFO pointers wrap modulo FifoDepth.
- Drain:
  - char_valid_o = FIFO non-empty && gap counter == 0; char_o = FIFO head.
  - Pop on char_valid_o&char_ready_i, which loads the gap counter with DrainGap.
  - char_o stays stable while valid and not ready.
- LSR reads are sampled in the RESP cycle.
- Reset asserted mid-transfer or mid-drain discards all state immediately.

Optional Feature:
APB_UART_SINK_PRINT_EN
- Defined:
  - Each popped byte is $write'n to the simulator console.
  - A 0x04 byte additionally triggers $display("EOT") and $finish.
- Undefined: no system tasks; synthesizable; the stream ports are the only output.

Decomposition:
- apb_uart_sink_pkg:
  - register offsets (THR/RBR=0x00, LSR=0x14, SCR=0x1C, window size 0x20)
  - LSR bit indices (DR=0, THRE=5, TEMT=6)
  - FSM enum state_e {IDLE, WAIT, RESP}
- Sub-module: common_cells fifo_v3 (DATA_WIDTH=8, DEPTH=FifoDepth) for the TX queue.
- Gap counter, FSM and decode stay in the top module.

Test Plan:
- Write 0x41 to 0x00, char_ready_i=1, WaitStates=1 → pready_o high in 2nd access cycle, pslverr_o=0; char_valid_o then pulses with char_o=0x41.
- char_ready_i=0; 17 THR writes with FifoDepth=16 → first 16 complete normally. The 17th holds pready_o=0 until char_ready_i=1 pops one byte, then completes. Output order is 0..16 in sequence.
- Read LSR after reset → prdata_o=0x60. After one THR write with char_ready_i=0 → 0x00. After the drain completes → 0x60.
- Write 0xA5A5_A5C3 to SCR, read back → 0x0000_00C3. Read 0x04 → 0, no error. Read 0x20 or 0x02 → pslverr_o=1, prdata_o=0, SCR unchanged.
- DrainGap=4, 3 queued bytes, char_ready_i=1 → char_valid_o pulses spaced exactly 5 cycles apart.
- Assert rst_ni low in WAIT with 5 bytes queued → all outputs 0 immediately. After release, LSR reads 0x60 and no stale byte appears on char_o.
